ex_mem_flag_stage: RTL and testbench

- EX/MEM pipeline register placed directly downstream of the 16-bit saturating ALU.
- Captures the ALU result, destination and memory controls into the MEM stage.
- Owns the architectural N/Z/V flag register and drives it back to the ALU flagsIn port.
- Resolves conditional branches against the committed flags and requests a front-end flush when a branch is taken.

---
 rtl/ex_mem_flag_stage.sv | 129 ++++++++++++
 tb/tb_ex_mem_flag_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register behind the saturating ALU: latches result and controls,
// owns the committed N/Z/V flags and resolves conditional branches against them.
module ex_mem_flag_stage #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_dst,
    input  logic          ex_N,
    input  logic          ex_Z,
    input  logic          ex_V,
    input  logic          ex_flag_we,
    input  logic          ex_is_branch,
    input  logic [2:0]    ex_cond,
    input  logic [DW-1:0] ex_target,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_reg_we,
    input  logic          ex_mem_re,
    input  logic          ex_mem_we,
    input  logic [DW-1:0] ex_store_data,
    output logic [2:0]    flags,
    output logic          branch_taken,
    output logic [DW-1:0] branch_pc,
    output logic          mem_valid,
    output logic          mem_reg_we,
    output logic          mem_mem_re,
    output logic          mem_mem_we,
    output logic [DW-1:0] mem_result,
    output logic [RW-1:0] mem_rd,
    output logic [DW-1:0] mem_store_data
);

    typedef enum logic [2:0] {
        COND_NEQ    = 3'd0,
        COND_EQ     = 3'd1,
        COND_GT     = 3'd2,
        COND_LT     = 3'd3,
        COND_GTE    = 3'd4,
        COND_LTE    = 3'd5,
        COND_OVFL   = 3'd6,
        COND_UNCOND = 3'd7
    } cond_e;

    typedef struct packed {
        logic          valid;
        logic          reg_we;
        logic          mem_re;
        logic          mem_we;
        logic [DW-1:0] result;
        logic [RW-1:0] rd;
        logic [DW-1:0] store_data;
    } mem_stage_t;

    mem_stage_t mem_q, mem_d;
    logic [2:0] flags_q, flags_d;
    logic       flag_n, flag_z, flag_v;
    logic       cond_true;

    assign {flag_n, flag_z, flag_v} = flags_q;

    // Branches see only committed flags; a same-cycle flag write is deliberately not bypassed.
    always_comb begin
        // NOTE: default first so no path through the case leaves cond_true unassigned (no latch).
        cond_true = 1'b0;
        unique case (cond_e'(ex_cond))
            COND_NEQ:    cond_true = ~flag_z;
            COND_EQ:     cond_true = flag_z;
            COND_GT:     cond_true = ~flag_z & ~flag_n;
            COND_LT:     cond_true = flag_n;
            COND_GTE:    cond_true = flag_z | ~flag_n;
            COND_LTE:    cond_true = flag_n | flag_z;
            COND_OVFL:   cond_true = flag_v;
            COND_UNCOND: cond_true = 1'b1;
        endcase
    end

    assign branch_taken = ex_valid & ex_is_branch & ~stall & ~flush & cond_true;
    assign branch_pc    = ex_target;

    always_comb begin
        mem_d   = mem_q;
        flags_d = flags_q;
        if (!stall) begin
            if (flush) begin
                // Bubble: kill controls only, data fields are don't-care and simply held.
                mem_d.valid  = 1'b0;
                mem_d.reg_we = 1'b0;
                mem_d.mem_re = 1'b0;
                mem_d.mem_we = 1'b0;
            end else begin
                mem_d.valid      = ex_valid;
                mem_d.reg_we     = ex_reg_we & ex_valid;
                mem_d.mem_re     = ex_mem_re & ex_valid;
                mem_d.mem_we     = ex_mem_we & ex_valid;
                mem_d.result     = ex_dst;
                mem_d.rd         = ex_rd;
                mem_d.store_data = ex_store_data;
                if (ex_valid && ex_flag_we) begin
                    flags_d = {ex_N, ex_Z, ex_V};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            mem_q   <= '0;
            flags_q <= 3'b000;
        end else begin
            mem_q   <= mem_d;
            flags_q <= flags_d;
        end
    end

    assign flags          = flags_q;
    assign mem_valid      = mem_q.valid;
    assign mem_reg_we     = mem_q.reg_we;
    assign mem_mem_re     = mem_q.mem_re;
    assign mem_mem_we     = mem_q.mem_we;
    assign mem_result     = mem_q.result;
    assign mem_rd         = mem_q.rd;
    assign mem_store_data = mem_q.store_data;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Self-checking bench for ex_mem_flag_stage: directed vector table, hand sequences
// for stall/flush/hazard/reset corners, then random traffic against a reference model.
module tb_ex_mem_flag_stage;

    typedef struct {
        logic        valid;
        logic [15:0] dst;
        logic [2:0]  nzv;
        logic        flag_we;
        logic        is_branch;
        logic [2:0]  cond;
        logic [15:0] target;
        logic [3:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic [15:0] sd;
    } ex_t;

    typedef struct {
        ex_t         e;
        logic        exp_taken;
        logic [2:0]  exp_flags;
        logic        exp_mem_valid;
        logic [15:0] exp_result;
        logic [3:0]  exp_rd;
        logic        exp_reg_we;
    } vec_t;

    logic clk = 1'b0;
    logic rst, stall, flush;
    logic ex_valid, ex_N, ex_Z, ex_V, ex_flag_we, ex_is_branch;
    logic ex_reg_we, ex_mem_re, ex_mem_we;
    logic [2:0]  ex_cond;
    logic [15:0] ex_dst, ex_target, ex_store_data;
    logic [3:0]  ex_rd;
    logic [2:0]  flags;
    logic        branch_taken;
    logic [15:0] branch_pc;
    logic        mem_valid, mem_reg_we, mem_mem_re, mem_mem_we;
    logic [15:0] mem_result, mem_store_data;
    logic [3:0]  mem_rd;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the MEM stage and flag register should hold.
    logic [2:0]  m_flags = 3'b000;
    logic        m_valid, m_reg_we, m_re, m_we;
    logic [15:0] m_result, m_sd;
    logic [3:0]  m_rd;
    bit          m_data_known = 1'b0;

    ex_mem_flag_stage #(.DW(16), .RW(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_dst(ex_dst), .ex_N(ex_N), .ex_Z(ex_Z), .ex_V(ex_V),
        .ex_flag_we(ex_flag_we), .ex_is_branch(ex_is_branch), .ex_cond(ex_cond),
        .ex_target(ex_target), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
        .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_store_data(ex_store_data),
        .flags(flags), .branch_taken(branch_taken), .branch_pc(branch_pc),
        .mem_valid(mem_valid), .mem_reg_we(mem_reg_we), .mem_mem_re(mem_mem_re),
        .mem_mem_we(mem_mem_we), .mem_result(mem_result), .mem_rd(mem_rd),
        .mem_store_data(mem_store_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic ex_t mk(input logic v, input logic [15:0] dst, input logic [2:0] nzv,
                               input logic fwe, input logic br, input logic [2:0] cond,
                               input logic [15:0] tgt, input logic [3:0] rd, input logic rwe,
                               input logic re, input logic we, input logic [15:0] sd);
        ex_t e;
        e.valid = v; e.dst = dst; e.nzv = nzv; e.flag_we = fwe; e.is_branch = br;
        e.cond = cond; e.target = tgt; e.rd = rd; e.reg_we = rwe; e.mem_re = re;
        e.mem_we = we; e.sd = sd;
        return e;
    endfunction

    function automatic ex_t rand_ex();
        return mk($urandom_range(0, 1), 16'($urandom), 3'($urandom), $urandom_range(0, 1),
                  $urandom_range(0, 1), 3'($urandom), 16'($urandom), 4'($urandom),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  16'($urandom));
    endfunction

    // Flags read as the outcome of a compare: Z = equal, N = less, V = overflow.
    function automatic logic cond_holds(input logic [2:0] cond, input logic [2:0] f);
        logic less, equal, ovf;
        less = f[2]; equal = f[1]; ovf = f[0];
        case (cond)
            3'd0:    return !equal;
            3'd1:    return equal;
            3'd2:    return !equal && !less;
            3'd3:    return less;
            3'd4:    return equal || !less;
            3'd5:    return less || equal;
            3'd6:    return ovf;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit s, input bit f, input ex_t e);
        if (r) begin
            m_flags = 3'b000; m_valid = 0; m_reg_we = 0; m_re = 0; m_we = 0;
            m_result = 0; m_rd = 0; m_sd = 0; m_data_known = 1;
        end else if (s) begin
            // everything holds
        end else if (f) begin
            m_valid = 0; m_reg_we = 0; m_re = 0; m_we = 0; m_data_known = 0;
        end else begin
            m_valid  = e.valid;
            m_reg_we = e.valid && e.reg_we;
            m_re     = e.valid && e.mem_re;
            m_we     = e.valid && e.mem_we;
            m_result = e.dst; m_rd = e.rd; m_sd = e.sd; m_data_known = 1;
            if (e.valid && e.flag_we) m_flags = e.nzv;
        end
    endtask

    task automatic compare_state();
        check("flags", flags, m_flags);
        check("mem_valid", mem_valid, m_valid);
        check("mem_reg_we", mem_reg_we, m_reg_we);
        check("mem_mem_re", mem_mem_re, m_re);
        check("mem_mem_we", mem_mem_we, m_we);
        if (m_data_known) begin
            check("mem_result", mem_result, m_result);
            check("mem_rd", mem_rd, m_rd);
            check("mem_store_data", mem_store_data, m_sd);
        end
    endtask

    // One clock: drive, check combinational branch outputs, clock, check registered state.
    task automatic cycle(input bit r, input bit s, input bit f, input ex_t e, output logic got_taken);
        rst = r; stall = s; flush = f;
        ex_valid = e.valid; ex_dst = e.dst; {ex_N, ex_Z, ex_V} = e.nzv;
        ex_flag_we = e.flag_we; ex_is_branch = e.is_branch; ex_cond = e.cond;
        ex_target = e.target; ex_rd = e.rd; ex_reg_we = e.reg_we;
        ex_mem_re = e.mem_re; ex_mem_we = e.mem_we; ex_store_data = e.sd;
        #1;
        got_taken = branch_taken;
        check("branch_taken", branch_taken,
              e.valid && e.is_branch && !s && !f && cond_holds(e.cond, m_flags));
        check("branch_pc", branch_pc, e.target);
        @(posedge clk);
        model_step(r, s, f, e);
        #1;
        compare_state();
    endtask

    vec_t tbl[10];
    logic tk;

    initial begin
        // Reset held two cycles with a valid instruction present.
        cycle(1, 0, 0, mk(1, 16'h1234, 3'b111, 1, 0, 0, 0, 4'd5, 1, 1, 1, 16'h5555), tk);
        cycle(1, 0, 0, mk(1, 16'h1234, 3'b111, 1, 0, 0, 0, 4'd5, 1, 1, 1, 16'h5555), tk);
        check("reset_flags", flags, 3'b000);
        check("reset_mem_valid", mem_valid, 1'b0);
        check("reset_mem_result", mem_result, 16'h0000);
        cycle(0, 0, 0, mk(1, 16'hBEEF, 3'b000, 0, 0, 0, 0, 4'd1, 0, 0, 0, 16'h0), tk);
        check("first_adv_result", mem_result, 16'hBEEF);

        // Directed table: flag-writing pipe, Z preload, then every branch condition.
        tbl[0] = '{mk(1, 16'h7FFF, 3'b001, 1, 0, 0, 0, 4'd3, 1, 0, 0, 16'h0),
                   1'b0, 3'b001, 1'b1, 16'h7FFF, 4'd3, 1'b1};
        tbl[1] = '{mk(1, 16'h0000, 3'b010, 1, 0, 0, 0, 4'd2, 0, 0, 0, 16'h0),
                   1'b0, 3'b010, 1'b1, 16'h0000, 4'd2, 1'b0};
        for (int i = 0; i < 8; i++) begin
            logic [7:0] taken_mask;
            taken_mask = 8'b1011_0010;
            tbl[2+i] = '{mk(1, 16'h0100 + 16'(i), 3'b000, 0, 1, 3'(i), 16'h00A4, 4'd0, 0, 0, 0, 16'h0),
                         taken_mask[i], 3'b010, 1'b1, 16'h0100 + 16'(i), 4'd0, 1'b0};
        end
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, tbl[i].e, tk);
            check($sformatf("tbl%0d_taken", i), tk, tbl[i].exp_taken);
            check($sformatf("tbl%0d_flags", i), flags, tbl[i].exp_flags);
            check($sformatf("tbl%0d_valid", i), mem_valid, tbl[i].exp_mem_valid);
            check($sformatf("tbl%0d_result", i), mem_result, tbl[i].exp_result);
            check($sformatf("tbl%0d_rd", i), mem_rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_reg_we", i), mem_reg_we, tbl[i].exp_reg_we);
        end

        // Stall for three cycles while EX changes and tries to write flags.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, mk(1, 16'hA000 + 16'(i), 3'b101, 1, 1, 3'd7, 16'h0040, 4'd9, 1, 1, 1, 16'h1), tk);
            check("stall_taken", tk, 1'b0);
            check("stall_result", mem_result, 16'h0107);
            check("stall_flags", flags, 3'b010);
        end
        cycle(0, 0, 0, mk(1, 16'hC0DE, 3'b001, 1, 0, 0, 0, 4'd7, 1, 0, 1, 16'h2222), tk);
        check("unstall_result", mem_result, 16'hC0DE);
        check("unstall_flags", flags, 3'b001);

        // Flush a valid flag-writing ADD, then stall+flush together must hold.
        cycle(0, 0, 1, mk(1, 16'h0000, 3'b010, 1, 0, 0, 0, 4'd4, 1, 0, 0, 16'h0), tk);
        check("flush_valid", mem_valid, 1'b0);
        check("flush_reg_we", mem_reg_we, 1'b0);
        check("flush_flags", flags, 3'b001);
        cycle(0, 0, 0, mk(1, 16'h1111, 3'b000, 0, 0, 0, 0, 4'd6, 1, 0, 0, 16'h0), tk);
        cycle(0, 1, 1, mk(1, 16'h9999, 3'b100, 1, 0, 0, 0, 4'd8, 0, 0, 0, 16'h0), tk);
        check("stall_flush_valid", mem_valid, 1'b1);
        check("stall_flush_result", mem_result, 16'h1111);

        // Back-to-back hazard: EQ sees the old Z until the write has committed.
        cycle(0, 0, 0, mk(1, 16'h0000, 3'b010, 1, 1, 3'd1, 16'h0080, 4'd1, 1, 0, 0, 16'h0), tk);
        check("hazard_old_flags", tk, 1'b0);
        cycle(0, 0, 0, mk(1, 16'h0000, 3'b000, 0, 1, 3'd1, 16'h0080, 4'd0, 0, 0, 0, 16'h0), tk);
        check("hazard_new_flags", tk, 1'b1);

        // Reset asserted mid-stall wins.
        cycle(0, 0, 0, mk(1, 16'h4444, 3'b111, 1, 0, 0, 0, 4'd2, 1, 1, 1, 16'h3), tk);
        cycle(1, 1, 0, mk(1, 16'h5555, 3'b111, 1, 0, 0, 0, 4'd2, 1, 1, 1, 16'h3), tk);
        check("rst_in_stall_valid", mem_valid, 1'b0);
        check("rst_in_stall_flags", flags, 3'b000);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit r, s, f;
            r = ($urandom_range(0, 31) == 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 5) == 0);
            cycle(r, s, f, rand_ex(), tk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
